// File: rtl/axi_test_pkg.sv
// Shared definitions for the AXI write responder: FSM states, BRESP and BURST codes.
package axi_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // DECERR outranks SLVERR, which outranks OKAY.
    function automatic logic [1:0] resp_code(input logic dec, input logic slv);
        if (dec) begin
            return RESP_DECERR;
        end
        if (slv) begin
            return RESP_SLVERR;
        end
        return RESP_OKAY;
    endfunction

endpackage

// File: rtl/resp_ram.sv
// Simple dual-port word RAM: byte-enabled write port, registered read port (old data on collision).
module resp_ram #(
    parameter  int DATA_W    = 32,
    parameter  int MEM_WORDS = 256,
    localparam int IDX_W     = $clog2(MEM_WORDS),
    localparam int LANES     = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [LANES-1:0]  wr_be,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    // One byte-wide array per lane keeps each lane a plain single-writer RAM.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] mem [MEM_WORDS];
            logic [7:0] rd_lane_reg;

            always_ff @(posedge clk) begin
                if (we && wr_be[gi]) begin
                    mem[wr_addr] <= wr_data[gi*8 +: 8];
                end
            end

            always_ff @(posedge clk) begin
                if (!rst) begin
                    rd_lane_reg <= '0;
                end else begin
                    rd_lane_reg <= mem[rd_addr];
                end
            end

            assign rd_data[gi*8 +: 8] = rd_lane_reg;
        end
    endgenerate

endmodule

// File: rtl/axi_wr_responder.sv
// AXI4 write-channel slave: one burst at a time into a local RAM, BRESP with error
// classification, and a rx_done strobe on each completed B handshake.
module axi_wr_responder
    import axi_test_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                MEM_WORDS = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W-1:0]            awaddr,
    input  logic [7:0]                   awlen,
    input  logic [2:0]                   awsize,
    input  logic [1:0]                   awburst,
    input  logic                         awvalid,
    output logic                         awready,
    input  logic [DATA_W-1:0]            wdata,
    input  logic [DATA_W/8-1:0]          wstrb,
    input  logic                         wlast,
    input  logic                         wvalid,
    output logic                         wready,
    output logic [1:0]                   bresp,
    output logic                         bvalid,
    input  logic                         bready,
    output logic                         rx_done,
    input  logic [$clog2(MEM_WORDS)-1:0] rd_addr,
    output logic [DATA_W-1:0]            rd_data
);

    localparam int                LANES     = DATA_W / 8;
    localparam int                IDX_W     = $clog2(MEM_WORDS);
    localparam int                LANE_SH   = $clog2(LANES);
    localparam logic [2:0]        SIZE_MAX  = 3'(LANE_SH);
    localparam logic [ADDR_W:0]   MEM_BYTES = (ADDR_W+1)'(MEM_WORDS * LANES);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [7:0]        len_reg, len_next;
    logic [2:0]        size_reg, size_next;
    logic [1:0]        burst_reg, burst_next;
    logic [7:0]        cnt_reg, cnt_next;
    logic              dec_err_reg, dec_err_next;
    logic              cfg_err_reg, cfg_err_next;
    logic              last_err_reg, last_err_next;
    logic              awready_reg, awready_next;
    logic              wready_reg, wready_next;
    logic              bvalid_reg, bvalid_next;
    logic [1:0]        bresp_reg, bresp_next;

    // Extra top bit catches addresses below BASE_ADDR as a borrow, so one compare covers both ends.
    logic [ADDR_W:0]   addr_off;
    logic              in_range;
    logic              beat;
    logic              last_beat;
    logic              ram_we;
    logic [IDX_W-1:0]  ram_idx;

    assign addr_off  = {1'b0, addr_reg} - {1'b0, BASE_ADDR};
    assign in_range  = (addr_off < MEM_BYTES);
    assign ram_idx   = IDX_W'(addr_off >> LANE_SH);
    assign beat      = wvalid && wready_reg;
    assign last_beat = (cnt_reg == len_reg);

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        len_next      = len_reg;
        size_next     = size_reg;
        burst_next    = burst_reg;
        cnt_next      = cnt_reg;
        dec_err_next  = dec_err_reg;
        cfg_err_next  = cfg_err_reg;
        last_err_next = last_err_reg;
        awready_next  = awready_reg;
        wready_next   = wready_reg;
        bvalid_next   = bvalid_reg;
        bresp_next    = bresp_reg;
        ram_we        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (awvalid && awready_reg) begin
                    addr_next     = awaddr;
                    len_next      = awlen;
                    size_next     = awsize;
                    burst_next    = awburst;
                    cnt_next      = '0;
                    dec_err_next  = 1'b0;
                    last_err_next = 1'b0;
                    cfg_err_next  = (awburst >= BURST_WRAP) || (awsize > SIZE_MAX);
                    awready_next  = 1'b0;
                    wready_next   = 1'b1;
                    state_next    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (beat) begin
                    ram_we = in_range && !cfg_err_reg;
                    if (!in_range) begin
                        dec_err_next = 1'b1;
                    end
                    if (wlast != last_beat) begin
                        last_err_next = 1'b1;
                    end
                    if (burst_reg == BURST_INCR) begin
                        addr_next = addr_reg + (ADDR_W'(1) << size_reg);
                    end
                    cnt_next = cnt_reg + 8'd1;
                    if (last_beat) begin
                        wready_next = 1'b0;
                        bvalid_next = 1'b1;
                        bresp_next  = resp_code(dec_err_next, cfg_err_reg || last_err_next);
                        state_next  = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (bready) begin
                    bvalid_next  = 1'b0;
                    awready_next = 1'b1;
                    state_next   = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            addr_reg     <= '0;
            len_reg      <= '0;
            size_reg     <= '0;
            burst_reg    <= BURST_FIXED;
            cnt_reg      <= '0;
            dec_err_reg  <= 1'b0;
            cfg_err_reg  <= 1'b0;
            last_err_reg <= 1'b0;
            awready_reg  <= 1'b1;
            wready_reg   <= 1'b0;
            bvalid_reg   <= 1'b0;
            bresp_reg    <= RESP_OKAY;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            len_reg      <= len_next;
            size_reg     <= size_next;
            burst_reg    <= burst_next;
            cnt_reg      <= cnt_next;
            dec_err_reg  <= dec_err_next;
            cfg_err_reg  <= cfg_err_next;
            last_err_reg <= last_err_next;
            awready_reg  <= awready_next;
            wready_reg   <= wready_next;
            bvalid_reg   <= bvalid_next;
            bresp_reg    <= bresp_next;
        end
    end

    resp_ram #(
        .DATA_W    (DATA_W),
        .MEM_WORDS (MEM_WORDS)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (ram_we),
        .wr_addr (ram_idx),
        .wr_be   (wstrb),
        .wr_data (wdata),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign awready = awready_reg;
    assign wready  = wready_reg;
    assign bvalid  = bvalid_reg;
    assign bresp   = bresp_reg;
    // A handshake coinciding with reset is discarded, so no completion strobe either.
    assign rx_done = bvalid_reg && bready && rst;

endmodule

// File: tb/tb_axi_wr_responder.sv
// Randomised bench for axi_wr_responder: byte-level RAM model plus a BRESP scoreboard/monitor.
module tb_axi_wr_responder;

    localparam int          ADDR_W    = 32;
    localparam int          DATA_W    = 32;
    localparam int          MEM_WORDS = 256;
    localparam logic [31:0] BASE      = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic        rx_done;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;

    always #5 clk = ~clk;

    axi_wr_responder #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MEM_WORDS (MEM_WORDS),
        .BASE_ADDR (BASE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .awaddr  (awaddr),
        .awlen   (awlen),
        .awsize  (awsize),
        .awburst (awburst),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wlast   (wlast),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .rx_done (rx_done),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    int          checks = 0;
    int          fails  = 0;
    logic [1:0]  exp_q [$];
    logic [1:0]  mon_exp;
    logic [31:0] mdl   [MEM_WORDS];
    bit          known [MEM_WORDS];
    logic [31:0] bd    [256];
    logic [3:0]  bs    [256];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every B handshake pops one expected response from the scoreboard.
    always begin
        @(negedge clk);
        #1;
        if (rst === 1'b1) begin
            if (bvalid && bready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL bresp_unexpected: got %0h, expected no response", bresp);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("bresp", {62'd0, bresp}, {62'd0, mon_exp});
                end
                chk("rx_done_on_handshake", {63'd0, rx_done}, 64'd1);
            end else if (bvalid || rx_done) begin
                chk("rx_done_without_handshake", {63'd0, rx_done}, 64'd0);
            end
        end
    end

    task automatic check_ram(input int w);
        @(negedge clk);
        rd_addr = w[7:0];
        @(negedge clk);
        if (known[w]) begin
            chk($sformatf("ram[%0d]", w), {32'd0, rd_data}, {32'd0, mdl[w]});
        end
    endtask

    task automatic check_ram_exp(input int w, input logic [31:0] exp);
        @(negedge clk);
        rd_addr = w[7:0];
        @(negedge clk);
        chk($sformatf("ram_const[%0d]", w), {32'd0, rd_data}, {32'd0, exp});
    endtask

    // One AW/W/B transaction. bad_last: beat index with inverted wlast (-1 none);
    // abort_after: reset after that many beats (-1 none); hold_aw: offer a new AW during backpressure.
    task automatic do_burst(input logic [31:0] addr, input int len, input int size,
                            input logic [1:0] burst, input int bad_last, input int abort_after,
                            input int bdelay, input bit hold_aw);
        longint      a;
        bit          in_rng;
        bit          dec;
        bit          cfg;
        bit          lerr;
        bit          chk_old;
        int          w;
        int          guard;
        int          gap;
        logic [31:0] old;
        logic [1:0]  exp;
        dec  = 0;
        lerr = 0;
        cfg  = (burst > 2'd1) || (size > 2);
        @(negedge clk);
        awaddr  = addr;
        awlen   = len[7:0];
        awsize  = size[2:0];
        awburst = burst;
        awvalid = 1'b1;
        guard   = 0;
        while (!awready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!awready) begin
            chk("aw_accept_timeout", 64'd0, 64'd1);
            awvalid = 1'b0;
            return;
        end
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            chk("wready_in_burst", {63'd0, wready}, 64'd1);
            a       = longint'(addr) + ((burst == 2'd1) ? (longint'(i) << size) : 64'd0);
            in_rng  = (a >= longint'(BASE)) && (a < longint'(BASE) + MEM_WORDS * 4);
            w       = in_rng ? int'((a - longint'(BASE)) >> 2) : 0;
            chk_old = in_rng && known[w];
            old     = mdl[w];
            wdata   = bd[i];
            wstrb   = bs[i];
            wlast   = (i == len) ^ (i == bad_last);
            wvalid  = 1'b1;
            rd_addr = w[7:0];
            @(negedge clk);
            wvalid = 1'b0;
            wlast  = 1'b0;
            if (chk_old) begin
                chk("rd_collision_old_data", {32'd0, rd_data}, {32'd0, old});
            end
            if (!in_rng) dec = 1;
            if (i == bad_last) lerr = 1;
            if (in_rng && !cfg) begin
                for (int j = 0; j < 4; j++) begin
                    if (bs[i][j]) mdl[w][8*j +: 8] = bd[i][8*j +: 8];
                end
                if (bs[i] == 4'hF) known[w] = 1;
            end
            if (abort_after >= 0 && i + 1 == abort_after) begin
                rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                repeat (3) begin
                    chk("abort_bvalid", {63'd0, bvalid}, 64'd0);
                    chk("abort_awready", {63'd0, awready}, 64'd1);
                    chk("abort_wready", {63'd0, wready}, 64'd0);
                    @(negedge clk);
                end
                return;
            end
        end
        exp = dec ? 2'b11 : ((cfg || lerr) ? 2'b10 : 2'b00);
        chk("bvalid_one_cycle_after_last", {63'd0, bvalid}, 64'd1);
        chk("wready_drop_after_last", {63'd0, wready}, 64'd0);
        for (int d = 0; d < bdelay; d++) begin
            if (hold_aw) begin
                awaddr  = 32'h0000_0100;
                awvalid = 1'b1;
            end
            chk("bvalid_hold", {63'd0, bvalid}, 64'd1);
            chk("bresp_hold", {62'd0, bresp}, {62'd0, exp});
            chk("awready_blocked", {63'd0, awready}, 64'd0);
            @(negedge clk);
        end
        awvalid = 1'b0;
        exp_q.push_back(exp);
        bready = 1'b1;
        guard  = 0;
        @(negedge clk);
        while (bvalid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (bvalid) chk("b_handshake_timeout", 64'd1, 64'd0);
        bready = 1'b0;
        chk("awready_after_b", {63'd0, awready}, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int addr_r;
        int len_r;
        int size_r;
        int r;
        logic [1:0] burst_r;
        int bad_r;
        rst     = 1'b0;
        awaddr  = '0;
        awlen   = '0;
        awsize  = '0;
        awburst = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wlast   = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        rd_addr = '0;
        for (int i = 0; i < MEM_WORDS; i++) known[i] = 0;
        repeat (2) @(negedge clk);
        chk("reset_awready", {63'd0, awready}, 64'd1);
        chk("reset_wready", {63'd0, wready}, 64'd0);
        chk("reset_bvalid", {63'd0, bvalid}, 64'd0);
        chk("reset_rx_done", {63'd0, rx_done}, 64'd0);
        chk("reset_rd_data", {32'd0, rd_data}, 64'd0);
        rst = 1'b1;

        // Fill the whole RAM with one 256-beat burst so every word is known.
        for (int i = 0; i < 256; i++) begin
            bd[i] = $urandom;
            bs[i] = 4'hF;
        end
        do_burst(BASE, 255, 2, 2'd1, -1, -1, 0, 0);
        repeat (8) check_ram($urandom_range(0, 255));

        for (int i = 0; i < 4; i++) begin
            bd[i] = 32'hA0 + i;
            bs[i] = 4'hF;
        end
        do_burst(BASE + 32'h10, 3, 2, 2'd1, -1, -1, 1, 0);
        for (int i = 0; i < 4; i++) check_ram_exp(4 + i, 32'hA0 + i);

        bd[0] = 32'h1122_3344;
        bs[0] = 4'hF;
        do_burst(BASE, 0, 2, 2'd1, -1, -1, 0, 0);
        bd[0] = 32'hDEAD_BEEF;
        bs[0] = 4'h3;
        do_burst(BASE, 0, 2, 2'd1, -1, -1, 0, 0);
        check_ram_exp(0, 32'h1122_BEEF);

        for (int i = 0; i < 256; i++) begin
            bd[i] = $urandom;
            bs[i] = 4'hF;
        end
        do_burst(BASE + 32'h400, 1, 2, 2'd1, -1, -1, 0, 0);
        check_ram(0);
        check_ram(1);
        do_burst(BASE + 32'h20, 3, 2, 2'd2, -1, -1, 0, 0);
        for (int i = 8; i < 12; i++) check_ram(i);
        do_burst(BASE + 32'h40, 3, 2, 2'd1, 1, -1, 0, 0);
        do_burst(BASE + 32'h60, 2, 2, 2'd1, 2, -1, 0, 0);
        do_burst(BASE + 32'h80, 1, 3, 2'd1, -1, -1, 0, 0);
        for (int i = 0; i < 4; i++) bs[i] = 4'($urandom);
        do_burst(BASE + 32'h90, 3, 2, 2'd0, -1, -1, 0, 0);
        do_burst(BASE + 32'hA0, 1, 2, 2'd1, -1, -1, 10, 1);
        do_burst(BASE + 32'hC0, 3, 2, 2'd1, -1, 2, 0, 0);
        for (int i = 16; i < 52; i++) check_ram(i);

        // W beats offered with no AW outstanding must be ignored.
        @(negedge clk);
        wdata  = 32'hBAD0_BAD0;
        wstrb  = 4'hF;
        wvalid = 1'b1;
        repeat (3) begin
            chk("wready_idle", {63'd0, wready}, 64'd0);
            @(negedge clk);
        end
        wvalid = 1'b0;

        for (int n = 0; n < 40; n++) begin
            addr_r = $urandom_range(0, 32'h47F);
            len_r  = $urandom_range(0, 15);
            r      = $urandom_range(0, 9);
            size_r = (r == 6) ? 0 : (r == 7) ? 1 : (r == 8) ? 3 : 2;
            r      = $urandom_range(0, 9);
            burst_r = (r < 8) ? 2'd1 : (r == 8) ? 2'd0 : 2'($urandom_range(2, 3));
            bad_r  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len_r) : -1;
            for (int i = 0; i <= len_r; i++) begin
                bd[i] = $urandom;
                bs[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            end
            do_burst(BASE + 32'(addr_r), len_r, size_r, burst_r, bad_r, -1,
                     $urandom_range(0, 3), 0);
        end

        for (int i = 0; i < MEM_WORDS; i++) check_ram(i);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
